// File: rtl/ps2_rx_frontend_if.sv
// Receive-side bus of the PS/2 front end: decoded byte, strobes, error cause, busy.
// master drives the bus (front end); slave consumes it (scan-code translator).
interface ps2_rx_frontend_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (output rx_data, rx_valid, rx_err, err_code, busy);
   modport slave  (input  rx_data, rx_valid, rx_err, err_code, busy);
endinterface

// File: rtl/ps2_rx_frontend.sv
// PS/2 receive front end: synchronizes key_clk/key_din, glitch-filters key_clk,
// deframes 11-bit frames and emits validated bytes or error strobes.
//
// state | meaning
// IDLE  | waiting for a start bit (filtered fall with data low)
// RECV  | shifting data bits 0..7, then parity (8), then stop (9)
// CHECK | one cycle; the verdict strobe taken at the stop-bit fall is visible here
module ps2_rx_frontend #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic clk25,
   input  logic rst_n,
   input  logic key_clk,
   input  logic key_din,
   ps2_rx_frontend_if.master rx
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_FRAMING = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int FILT_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   clk_s;
   logic                   din_s;

   logic [FILT_W-1:0] filt_cnt;
   logic              filt_lvl;
   logic              filt_prev;
   logic              fall_stb;

   logic [1:0]       state;
   logic [3:0]       bit_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       shift_reg;
   logic             parity_bit;

   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       rx_err_q;
   logic [1:0] err_code_q;
   logic       busy_q;

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign din_s    = din_sync[SYNC_STAGES-1];
   assign fall_stb = filt_prev & ~filt_lvl;

   // Synchronizers reset high so an idle bus never looks like a start edge.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         clk_sync <= '1;
         din_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], key_clk};
         din_sync <= {din_sync[SYNC_STAGES-2:0], key_din};
      end
   end

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         filt_cnt  <= '0;
         filt_lvl  <= 1'b1;
         filt_prev <= 1'b1;
      end else begin
         filt_prev <= filt_lvl;
         if (clk_s != filt_lvl) begin
            if (filt_cnt == FILT_LAST) begin
               filt_lvl <= clk_s;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         err_code_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               bit_cnt <= '0;
               if (fall_stb && !din_s) begin
                  state  <= RECV;
                  busy_q <= 1'b1;
               end
            end
            RECV: begin
               // A fall in the expiry cycle wins: it restarts the timeout instead.
               if (fall_stb) begin
                  tmo_cnt <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     shift_reg <= {din_s, shift_reg[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                     parity_bit <= din_s;
                  end else begin
                     state   <= CHECK;
                     bit_cnt <= '0;
                     if (!din_s) begin
                        rx_err_q   <= 1'b1;
                        err_code_q <= ERR_FRAMING;
                     end else if (!(^{shift_reg, parity_bit})) begin
                        rx_err_q   <= 1'b1;
                        err_code_q <= ERR_PARITY;
                     end else begin
                        rx_data_q  <= shift_reg;
                        rx_valid_q <= 1'b1;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  rx_err_q   <= 1'b1;
                  err_code_q <= ERR_TIMEOUT;
                  state      <= IDLE;
                  busy_q     <= 1'b0;
                  shift_reg  <= '0;
                  bit_cnt    <= '0;
                  tmo_cnt    <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            CHECK: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx.rx_data  = rx_data_q;
   assign rx.rx_valid = rx_valid_q;
   assign rx.rx_err   = rx_err_q;
   assign rx.err_code = err_code_q;
   assign rx.busy     = busy_q;

endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
Robust PS/2 receive front end that sits directly upstream of the keyboard scan-code translator.
- Brings raw key_clk/key_din into the clk25 domain and glitch-filters the PS/2 clock.
- Deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Delivers each validated scan-code byte with a one-cycle strobe; malformed frames are reported as errors instead of being passed on.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on key_clk and key_din (minimum 2).
- FILTER_LEN, 8, consecutive identical synchronized key_clk samples required before the filtered clock level changes.
- TIMEOUT_CYCLES, 25000, clk25 cycles without a filtered falling edge while mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
- clk25  input  1  system clock, 25 MHz
- rst_n  input  1  reset, synchronous, active-low
- key_clk  input  1  raw PS/2 clock from device, asynchronous
- key_din  input  1  raw PS/2 data from device, asynchronous
- rx_data  output  8  last correctly received scan-code byte
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle
- rx_err  output  1  one-cycle strobe: frame rejected
- err_code  output  2  cause of last rejection: 01 parity, 10 framing, 11 timeout; holds until the next error
- busy  output  1  high while a frame is being received

Behaviour:
- Interface: one clock, clk25. Reset rst_n is synchronous and active-low; all state changes on the rising clk25 edge.
- Reset values:
  - rx_data=0x00, rx_valid=0, rx_err=0, err_code=00, busy=0.
  - Synchronizer flops=1 and filtered clock level=1 (bus idle high).
  - Filter and timeout counters=0, bit counter=0, state IDLE.
- Synchronization: key_clk and key_din each pass through SYNC_STAGES flops; only synchronized values are used downstream.
- Glitch filter:
  - Counter increments while the synchronized key_clk differs from the filtered level; it clears to 0 whenever they match.
  - When the counter reaches FILTER_LEN-1 with the mismatch still present, the filtered level flips and the counter clears.
  - Any pulse shorter than FILTER_LEN cycles has no effect.
- Edge detect: fall_stb=1 for exactly one cycle when the filtered level goes 1->0. Data is sampled from synchronized key_din in that cycle.
- State machine:
  - IDLE: on fall_stb with data=0 (start bit), go to RECV with bit counter=0 and busy=1. On fall_stb with data=1, stay in IDLE with no output.
  - RECV, bit counter 0..7: shift data into an 8-bit register LSB first.
  - RECV, bit counter 8: capture the parity bit.
  - RECV, bit counter 9: capture the stop bit, then go to CHECK.
  - CHECK (one cycle): evaluate the frame as described below, then go to IDLE with busy=0.
- Frame check in CHECK:
  - Stop bit 0 gives a framing error, which has priority over a parity error.
  - Otherwise, XOR of the 8 data bits and the parity bit must equal 1 (odd parity); if not, parity error.
  - Good frame: rx_data is loaded and rx_valid=1 in the cycle after the stop-bit fall_stb.
  - Bad frame: rx_err=1 and err_code is set in that same cycle; rx_data is unchanged.
- Timeout:
  - In RECV, a counter clears on every fall_stb and otherwise increments.
  - On reaching TIMEOUT_CYCLES-1 it asserts rx_err with err_code=11 for one cycle, returns to IDLE, clears busy and discards partial data.
  - The counter is held at 0 in IDLE.
- Latency: raw key_clk fall to fall_stb is SYNC_STAGES+FILTER_LEN cycles, ±1 for synchronizer phase. fall_stb of the stop bit to rx_valid is 1 cycle.
- Exclusivity: rx_valid and rx_err are never high in the same cycle. Each frame produces at most one strobe.
- Simultaneous events: if fall_stb and timeout expiry occur in the same cycle, fall_stb wins and the timeout is suppressed.
- Back-to-back frames: a start bit arriving in the cycle right after CHECK is accepted normally.
- Reset mid-frame: the partial frame is dropped, no strobe is issued, and all values return to reset values on the next edge.
- No flow control: the consumer must take rx_data on the rx_valid cycle. A new byte overwrites rx_data.

Test Plan:
- Clean frame: 0x1C (three 1s, parity bit 0, stop 1) at an 80 us bit period (2000 cycles) -> exactly one rx_valid, rx_data=0x1C, rx_err never asserted, busy high from start bit to CHECK.
- Parity error: 0x1C sent with parity bit 1 -> one rx_err, err_code=01, rx_data keeps its previous value, no rx_valid.
- Framing error: 0xF0 (parity bit 1) sent with stop=0 and also a deliberately wrong parity bit -> rx_err, err_code=10 (framing has priority).
- Glitch rejection: 3-cycle low pulses on key_clk, in idle and mid-frame between edges, while sending 0x5A (parity bit 1) -> no extra bits captured, rx_data=0x5A, one rx_valid.
- Timeout and recovery: stop clocking after 5 bits and wait 25000 cycles -> rx_err with err_code=11, busy=0. A following clean 0xF0 frame -> rx_valid, rx_data=0xF0.
- Reset mid-frame: assert rst_n=0 for 1 cycle after bit 4, then send 0x12 -> no strobe from the aborted frame, all outputs at reset values after reset, then rx_data=0x12.
